// File: rtl/xoroshiro_arbiter_if.sv
// xoroshiro_arbiter_if: consumer-side bundle of the shared PRNG arbiter.
//
// Handshake rules:
//   seed      : a seed transfers on a rising clock edge where seed_valid and
//               seed_ready are both high; the offerer holds seed_valid/seed
//               stable until that edge.
//   req/gnt   : req is a level per requester; every cycle gnt is high for a
//               requester counts as one number owed to it.
//   rnd_valid : one-cycle pulse, no backpressure, one cycle after gnt;
//               rnd_data is meaningful only while rnd_valid is high.
interface xoroshiro_arbiter_if #(
    parameter int N_REQ = 4
);
    logic               seed_valid;
    logic               seed_ready;
    logic [127:0]       seed;
    logic [N_REQ-1:0]   req;
    logic [N_REQ-1:0]   gnt;
    logic [N_REQ-1:0]   rnd_valid;
    logic [63:0]        rnd_data;
    logic               rdy;

    modport master (
        output seed_valid, seed, req,
        input  seed_ready, gnt, rnd_valid, rnd_data, rdy
    );

    modport slave (
        input  seed_valid, seed, req,
        output seed_ready, gnt, rnd_valid, rnd_data, rdy
    );
endinterface

// File: rtl/xoroshiro_arbiter.sv
// xoroshiro_arbiter: seeds one xoroshiro128plus core and shares its output
// among N_REQ requesters with a round-robin arbiter, one number per grant.
// Optional warm-up discard phase is compiled in with XORO_ARB_WARMUP_EN.
// dbg_state exposes the FSM state for observation.
module xoroshiro_arbiter #(
    parameter int N_REQ  = 4,
    parameter int WARMUP = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    xoroshiro_arbiter_if.slave bus,
    output logic            core_load,
    output logic            core_en,
    output logic [127:0]    core_seed,
    input  logic [63:0]     core_out,
    output logic [1:0]      dbg_state
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEED   = 2'd1,
`ifdef XORO_ARB_WARMUP_EN
        S_WARMUP = 2'd2,
`endif
        S_READY  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [PW-1:0]      r_ptr;
    logic [PW-1:0]      w_ptr_next;
    logic [N_REQ-1:0]   w_gnt;
    logic [N_REQ-1:0]   r_rnd_valid;
    logic [63:0]        r_rnd_data;
    logic [127:0]       r_core_seed;
    logic               w_seed_ready;
    logic               w_seed_acc;
    logic               w_arb_en;
    logic               w_found;
    logic [PW-1:0]      w_win;
    logic [PW-1:0]      w_idx;
    logic [PW:0]        w_sum;

`ifdef XORO_ARB_WARMUP_EN
    localparam logic [7:0] WARMUP_LEN = 8'(WARMUP);
    logic [7:0]         r_wcnt;
    logic [7:0]         w_wcnt_next;
`else
    // WARMUP has no effect in this build.
    wire [7:0]          w_unused_warmup = 8'(WARMUP);
`endif

    // A seed offer in READY wins over arbitration for that cycle.
    assign w_seed_acc = bus.seed_valid && w_seed_ready;
    assign w_arb_en   = (r_state == S_READY) && !bus.seed_valid;

    // Round-robin search: first requester at or after r_ptr, wrapping.
    always_comb begin
        w_gnt   = '0;
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        w_sum   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_sum = {1'b0, r_ptr} + (PW+1)'(i);
            if (w_sum >= (PW+1)'(N_REQ)) begin
                w_sum = w_sum - (PW+1)'(N_REQ);
            end
            w_idx = w_sum[PW-1:0];
            if (w_arb_en && !w_found && bus.req[w_idx]) begin
                w_found      = 1'b1;
                w_win        = w_idx;
                w_gnt[w_idx] = 1'b1;
            end
        end
    end

    // Pointer moves past the winner; held when nobody is granted.
    always_comb begin
        w_ptr_next = r_ptr;
        if (w_found) begin
            w_ptr_next = (w_win == PW'(N_REQ - 1)) ? '0 : w_win + 1'b1;
        end
    end

    // Next-state and combinational core controls.
    always_comb begin
        w_state_next = r_state;
        core_load    = 1'b0;
        core_en      = |w_gnt;
        w_seed_ready = 1'b0;
`ifdef XORO_ARB_WARMUP_EN
        w_wcnt_next  = r_wcnt;
`endif
        unique case (r_state)
            S_IDLE: begin
                w_seed_ready = 1'b1;
                if (bus.seed_valid) w_state_next = S_SEED;
            end
            S_SEED: begin
                core_load = 1'b1;
`ifdef XORO_ARB_WARMUP_EN
                if (WARMUP_LEN != 8'd0) begin
                    w_state_next = S_WARMUP;
                    w_wcnt_next  = WARMUP_LEN;
                end else begin
                    w_state_next = S_READY;
                end
`else
                w_state_next = S_READY;
`endif
            end
`ifdef XORO_ARB_WARMUP_EN
            S_WARMUP: begin
                core_en     = 1'b1;
                w_wcnt_next = r_wcnt - 8'd1;
                if (r_wcnt == 8'd1) w_state_next = S_READY;
            end
`endif
            S_READY: begin
                w_seed_ready = 1'b1;
                if (bus.seed_valid) w_state_next = S_SEED;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State, pointer, seed capture and delivery registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_rnd_valid <= '0;
            r_rnd_data  <= '0;
            r_core_seed <= '0;
        end else begin
            r_state     <= w_state_next;
            r_ptr       <= w_ptr_next;
            r_rnd_valid <= w_gnt;
            if (|w_gnt) r_rnd_data <= core_out;
            if (w_seed_acc) r_core_seed <= bus.seed;
        end
    end

`ifdef XORO_ARB_WARMUP_EN
    // Warm-up down-counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wcnt <= 8'd0;
        end else begin
            r_wcnt <= w_wcnt_next;
        end
    end
`endif

    assign bus.seed_ready = w_seed_ready;
    assign bus.gnt        = w_gnt;
    assign bus.rnd_valid  = r_rnd_valid;
    assign bus.rnd_data   = r_rnd_data;
    assign bus.rdy        = (r_state == S_READY);
    assign core_seed      = r_core_seed;
    assign dbg_state      = r_state;

endmodule
